piso_rr_sched: RTL and testbench

PISO_RR_SCHED -- requirements
Module: piso_rr_sched

---
 rtl/piso_sched_pkg.sv | 16 +
 rtl/piso_rr_sched_arbiter.sv | 31 +++
 rtl/piso_rr_sched.sv | 91 +++++++++
 tb/tb_piso_rr_sched.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/piso_sched_pkg.sv
// piso_sched_pkg: shared defaults, state type and word length for piso_rr_sched.
// Build option: PISO_SCHED_PARITY_EN appends one even-parity bit to each word.
package piso_sched_pkg;
   localparam int NUM_REQ_DEF = 4;
   localparam int WIDTH_DEF   = 4;
`ifdef PISO_SCHED_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int WORD_LEN_DEF = WIDTH_DEF + PAR_BITS;
   typedef enum logic {IDLE, SHIFT} state_t;
   function automatic int word_len(input int width);
      return width + PAR_BITS;
   endfunction
endpackage

// File: rtl/piso_rr_sched_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr.
// Ports: req (request vector), ptr (highest-priority index),
//        gnt (one-hot winner), idx (winner index), any (some request present).
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);
   logic          w_found;
   logic [IW-1:0] w_j;
   always_comb begin
      gnt     = '0;
      idx     = '0;
      w_found = 1'b0;
      w_j     = '0;
      for (int k = 0; k < N; k++) begin
         w_j = IW'((int'(ptr) + k) % N);
         if (!w_found && req[w_j]) begin
            w_found  = 1'b1;
            gnt[w_j] = 1'b1;
            idx      = w_j;
         end
      end
   end
   assign any = |req;
endmodule

// File: rtl/piso_rr_sched.sv
// piso_rr_sched: round-robin scheduler feeding one LSB-first serializer.
// Ports: clk, reset (sync, active-high), req_i/data_i (per-requester word),
//        gnt_o (grant pulse on bit 0), serial_o/valid_o (serial payload),
//        owner_o (owner of word in flight), empty_o (nothing in flight).
// Build option: PISO_SCHED_PARITY_EN adds an even-parity bit after the data.
module piso_rr_sched
   import piso_sched_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int WIDTH   = WIDTH_DEF
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_i,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]    data_i,
   output logic [NUM_REQ-1:0]               gnt_o,
   output logic                             serial_o,
   output logic                             valid_o,
   output logic [$clog2(NUM_REQ)-1:0]       owner_o,
   output logic                             empty_o
);
   localparam int IW   = $clog2(NUM_REQ);
   localparam int WLEN = word_len(WIDTH);
   localparam int CW   = $clog2(WLEN + 1);

   state_t               r_state;
   logic [WLEN-1:0]      r_sh;
   logic [CW-1:0]        r_cnt;
   logic [IW-1:0]        r_ptr;
   logic [IW-1:0]        r_owner;
   logic [NUM_REQ-1:0]   r_gnt;

   logic [NUM_REQ-1:0]   w_gnt;
   logic [IW-1:0]        w_idx;
   logic                 w_any;
   logic                 w_last;
   logic                 w_load;
   logic [WLEN-1:0]      w_word;

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
      .req (req_i),
      .ptr (r_ptr),
      .gnt (w_gnt),
      .idx (w_idx),
      .any (w_any)
   );

   assign w_last = (r_state == SHIFT) && (r_cnt == CW'(WLEN - 1));
   // Requests are only looked at when idle or on the final bit, so the next
   // word follows the current one with no bubble.
   assign w_load = w_any && ((r_state == IDLE) || w_last);
`ifdef PISO_SCHED_PARITY_EN
   assign w_word = {^data_i[w_idx], data_i[w_idx]};
`else
   assign w_word = data_i[w_idx];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_sh    <= '0;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_owner <= '0;
         r_gnt   <= '0;
      end else if (w_load) begin
         r_state <= SHIFT;
         r_sh    <= w_word;
         r_cnt   <= '0;
         r_gnt   <= w_gnt;
         r_owner <= w_idx;
         r_ptr   <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
      end else if (w_last) begin
         r_state <= IDLE;
         r_sh    <= '0;
         r_cnt   <= '0;
         r_gnt   <= '0;
         r_owner <= '0;
      end else if (r_state == SHIFT) begin
         r_sh    <= r_sh >> 1;
         r_cnt   <= r_cnt + CW'(1);
         r_gnt   <= '0;
      end
   end

   assign valid_o  = (r_state == SHIFT);
   assign serial_o = valid_o & r_sh[0];
   assign gnt_o    = r_gnt;
   assign owner_o  = r_owner;
   assign empty_o  = (r_state == IDLE);
endmodule

// File: tb/tb_piso_rr_sched.sv
// tb_piso_rr_sched: directed and random checks of piso_rr_sched against a word-level model.
module tb_piso_rr_sched;
   localparam int N = 4;
   localparam int W = 4;
`ifdef PISO_SCHED_PARITY_EN
   localparam int WL = W + 1;
`else
   localparam int WL = W;
`endif

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [N-1:0]         req_i = '0;
   logic [N-1:0][W-1:0]  data_i = '0;
   logic [N-1:0]         gnt_o;
   logic                 serial_o;
   logic                 valid_o;
   logic [1:0]           owner_o;
   logic                 empty_o;

   int n_chk = 0;
   int n_err = 0;

   bit m_busy = 0;
   int m_pos = 0;
   int m_word = 0;
   int m_owner = 0;
   int m_ptr = 0;

   piso_rr_sched #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .req_i    (req_i),
      .data_i   (data_i),
      .gnt_o    (gnt_o),
      .serial_o (serial_o),
      .valid_o  (valid_o),
      .owner_o  (owner_o),
      .empty_o  (empty_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Compare the current cycle with the model, then apply inputs for the next edge.
   task automatic cyc(input bit rs, input logic [N-1:0] rq, input logic [N-1:0][W-1:0] dv);
      check("valid", int'(valid_o), int'(m_busy));
      check("serial", int'(serial_o), m_busy ? ((m_word >> m_pos) & 1) : 0);
      check("gnt", int'(gnt_o), (m_busy && m_pos == 0) ? (1 << m_owner) : 0);
      check("owner", int'(owner_o), m_busy ? m_owner : 0);
      check("empty", int'(empty_o), m_busy ? 0 : 1);
      reset  = rs;
      req_i  = rq;
      data_i = dv;
      if (rs) begin
         m_busy = 0;
         m_ptr  = 0;
      end else if (!m_busy || m_pos == WL - 1) begin
         m_busy = 0;
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (!m_busy && rq[c]) begin
               m_busy  = 1;
               m_owner = c;
               m_pos   = 0;
               m_word  = int'(dv[c]);
`ifdef PISO_SCHED_PARITY_EN
               m_word  = m_word | (($countones(dv[c]) % 2) << W);
`endif
            end
         end
         if (m_busy) m_ptr = (m_owner + 1) % N;
      end else begin
         m_pos++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [N-1:0][W-1:0] d;
      logic [3:0]          eb;
      logic [N-1:0]        rq;
      d = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      // reset state is compared by the first cyc
      cyc(0, '0, d);

      // single request from requester 2, word B
      d[2] = 4'hB;
      eb   = 4'hB;
      cyc(0, 4'b0100, d);
      check("r029_gnt", int'(gnt_o), 4);
      for (int i = 0; i < 4; i++) begin
         check("r029_bit", int'(serial_o), int'(eb[i]));
         cyc(0, '0, d);
      end
      repeat (WL - 4) cyc(0, '0, d);
      check("r029_empty", int'(empty_o), 1);

      // everyone requesting after reset
      cyc(1, '0, d);
      d[0] = 4'h1; d[1] = 4'h2; d[2] = 4'h3; d[3] = 4'h4;
      cyc(0, 4'hF, d);
      for (int i = 0; i < 20; i++) begin
         if (i % WL == 0) check("r030_owner", int'(owner_o), (i / WL) % N);
         check("r030_valid", int'(valid_o), 1);
         cyc(0, 4'hF, d);
      end

      // fairness after granting requester 1
      cyc(1, '0, d);
      cyc(0, 4'b0010, d);
      repeat (WL) cyc(0, 4'b0011, d);
      check("r031_a_owner", int'(owner_o), 0);
      check("r031_a_gnt", int'(gnt_o), 1);
      cyc(1, '0, d);
      cyc(0, 4'b0010, d);
      repeat (WL) cyc(0, 4'b0110, d);
      check("r031_b_owner", int'(owner_o), 2);
      check("r031_b_gnt", int'(gnt_o), 4);

      // reset in the middle of a word
      cyc(1, '0, d);
      d[0] = 4'hA;
      cyc(0, 4'b0001, d);
      cyc(0, '0, d);
      cyc(0, '0, d);
      cyc(1, '0, d);
      check("r032_valid", int'(valid_o), 0);
      check("r032_serial", int'(serial_o), 0);
      check("r032_empty", int'(empty_o), 1);
      cyc(0, 4'b1001, d);
      check("r032_gnt", int'(gnt_o), 1);

      // idle gap between words
      repeat (WL) cyc(0, '0, d);
      d[0] = 4'h5;
      cyc(0, 4'b0001, d);
      repeat (WL) cyc(0, '0, d);
      check("r033_idle", int'(valid_o), 0);
      repeat (4) cyc(0, '0, d);
      cyc(0, 4'b0001, d);
      check("r033_first_valid", int'(valid_o), 1);
      check("r033_first_bit", int'(serial_o), 1);

      // random traffic; data only changes while its request is low
      for (int t = 0; t < 600; t++) begin
         rq = req_i;
         for (int i = 0; i < N; i++) begin
            if (!rq[i]) d[i] = W'($urandom);
            rq[i] = ($urandom % 3) != 0 ? rq[i] : ~rq[i];
         end
         cyc(($urandom % 60) == 0, rq, d);
      end
      cyc(0, '0, d);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
